isr_ack_controller: RTL and testbench

- Sits directly downstream of the priority resolver in the 8259 PIC.
- Consumes PriorityID/INTFLAG, drives the CPU INT line, and runs the two-pulse INTA handshake.
- Owns the In-Service register and returns IS_status and last_serviced to the resolver.
- Handles non-specific and specific EOI commands and emits one-cycle IRR-clear strobes to the request register.

---
 rtl/isr_ack_controller.sv | 175 +++++++++++++++++
 tb/tb_isr_ack_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/isr_ack_controller.sv
// isr_ack_controller
//   In-Service / INTA handshake block of the 8259 PIC, downstream of the
//   priority resolver. It raises INT, runs the two-pulse INTA sequence,
//   owns the In-Service register and executes non-specific / specific EOI.
//
// Ports
//   clk, reset           system clock, asynchronous active-high reset
//   INTFLAG, PriorityID  resolver request flag and winning IR level
//   Rotating_priority    1 = rotate-on-EOI rule for non-specific EOI
//   INTA_n               CPU acknowledge (active low, synchronous to clk)
//   EOI, SEOI, EOI_level non-specific / specific EOI pulses and SEOI level
//   VectorBase           T7..T3 of the vector byte
//   AEOI                 auto-EOI enable (only with PIC_AEOI_EN defined)
//   INT                  interrupt request to the CPU
//   IS_status            In-Service register
//   last_serviced        rotation reference for the resolver
//   IRR_clear            one-hot, one-cycle clear strobe for the IRR
//   data_out, data_out_en vector byte {VectorBase, ID} and its drive enable
//
// Build option: define PIC_AEOI_EN to add the AEOI port and auto-EOI.
module isr_ack_controller #(
  parameter logic [2:0] SPURIOUS_ID = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INTFLAG,
  input  logic [2:0] PriorityID,
  input  logic       Rotating_priority,
  input  logic       INTA_n,
  input  logic       EOI,
  input  logic       SEOI,
  input  logic [2:0] EOI_level,
  input  logic [4:0] VectorBase,
`ifdef PIC_AEOI_EN
  input  logic       AEOI,
`endif
  output logic       INT,
  output logic [7:0] IS_status,
  output logic [2:0] last_serviced,
  output logic [7:0] IRR_clear,
  output logic [7:0] data_out,
  output logic       data_out_en
);

  typedef enum logic [1:0] {IDLE, PENDING, ACK1, ACK2} state_t;

  state_t     state;
  logic       inta_prev;
  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] id;

  logic       ack_set;
  logic       eoi_found;
  logic [2:0] eoi_target;
  logic [2:0] scan_idx;
  logic [7:0] set_mask;
  logic [7:0] clr_mask;
  logic [7:0] is_next;
  logic [2:0] ls_next;

`ifdef PIC_AEOI_EN
  logic       spurious;
  logic       aeoi_clr;
`endif

  assign inta_fall = inta_prev & ~INTA_n;
  assign inta_rise = ~inta_prev & INTA_n;
  assign ack_set   = (state == PENDING) && inta_fall && INTFLAG;

  // Non-specific EOI target: fixed mode scans 0..7, rotating mode scans
  // upward from last_serviced+1 with wrap. First set bit wins.
  always_comb begin
    eoi_found  = 1'b0;
    eoi_target = '0;
    scan_idx   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      scan_idx = Rotating_priority ? last_serviced + 3'(i + 1) : 3'(i);
      if (!eoi_found && IS_status[scan_idx]) begin
        eoi_found  = 1'b1;
        eoi_target = scan_idx;
      end
    end
  end

  // Clears are computed from the pre-set IS value; OR-ing the set mask in
  // last makes a same-cycle INTA-1 set win over a clear of the same bit.
  always_comb begin
    set_mask = ack_set ? (8'b1 << PriorityID) : '0;
    clr_mask = '0;
    ls_next  = last_serviced;
`ifdef PIC_AEOI_EN
    aeoi_clr = (state == ACK2) && inta_rise && AEOI && !spurious;
    if (aeoi_clr) begin
      clr_mask = 8'b1 << id;
      if (Rotating_priority)
        ls_next = id;
    end
`endif
    if (SEOI) begin
      clr_mask = clr_mask | (8'b1 << EOI_level);
      if (Rotating_priority)
        ls_next = EOI_level;
    end else if (EOI && eoi_found) begin
      clr_mask = clr_mask | (8'b1 << eoi_target);
      if (Rotating_priority)
        ls_next = eoi_target;
    end
    is_next = (IS_status & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      inta_prev     <= 1'b1;
      id            <= '0;
      INT           <= 1'b0;
      IS_status     <= '0;
      last_serviced <= 3'd7;
      IRR_clear     <= '0;
      data_out      <= '0;
      data_out_en   <= 1'b0;
`ifdef PIC_AEOI_EN
      spurious      <= 1'b0;
`endif
    end else begin
      inta_prev     <= INTA_n;
      IRR_clear     <= '0;
      IS_status     <= is_next;
      last_serviced <= ls_next;
      case (state)
        IDLE: begin
          if (INTFLAG) begin
            INT   <= 1'b1;
            state <= PENDING;
          end
        end
        PENDING: begin
          // An INTA fall takes precedence over a same-cycle INTFLAG drop.
          if (inta_fall) begin
            INT   <= 1'b0;
            state <= ACK1;
            if (INTFLAG) begin
              id        <= PriorityID;
              IRR_clear <= 8'b1 << PriorityID;
            end else begin
              id <= SPURIOUS_ID;
            end
`ifdef PIC_AEOI_EN
            spurious <= !INTFLAG;
`endif
          end else if (!INTFLAG) begin
            INT   <= 1'b0;
            state <= IDLE;
          end
        end
        ACK1: begin
          if (inta_fall) begin
            data_out    <= {VectorBase, id};
            data_out_en <= 1'b1;
            state       <= ACK2;
          end
        end
        ACK2: begin
          if (inta_rise) begin
            data_out_en <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isr_ack_controller.sv
// tb_isr_ack_controller
//   Directed bench for isr_ack_controller: handshake, EOI rules, spurious
//   acknowledge, SEOI/EOI collision, reset mid-handshake, and auto-EOI when
//   PIC_AEOI_EN is defined.
module tb_isr_ack_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       INTFLAG;
  logic [2:0] PriorityID;
  logic       Rotating_priority;
  logic       INTA_n;
  logic       EOI;
  logic       SEOI;
  logic [2:0] EOI_level;
  logic [4:0] VectorBase;
`ifdef PIC_AEOI_EN
  logic       AEOI;
`endif
  logic       INT;
  logic [7:0] IS_status;
  logic [2:0] last_serviced;
  logic [7:0] IRR_clear;
  logic [7:0] data_out;
  logic       data_out_en;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  isr_ack_controller #(.SPURIOUS_ID(3'd7)) dut (
    .clk               (clk),
    .reset             (reset),
    .INTFLAG           (INTFLAG),
    .PriorityID        (PriorityID),
    .Rotating_priority (Rotating_priority),
    .INTA_n            (INTA_n),
    .EOI               (EOI),
    .SEOI              (SEOI),
    .EOI_level         (EOI_level),
    .VectorBase        (VectorBase),
`ifdef PIC_AEOI_EN
    .AEOI              (AEOI),
`endif
    .INT               (INT),
    .IS_status         (IS_status),
    .last_serviced     (last_serviced),
    .IRR_clear         (IRR_clear),
    .data_out          (data_out),
    .data_out_en       (data_out_en)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full two-pulse acknowledge of level lvl; returns in IDLE with INTFLAG=0.
  task automatic ack(input logic [2:0] lvl);
    INTFLAG = 1'b1; PriorityID = lvl;
    step();
    INTA_n = 1'b0;
    step();
    INTFLAG = 1'b0; INTA_n = 1'b1;
    step();
    INTA_n = 1'b0;
    step();
    INTA_n = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b1; INTFLAG = 1'b0; PriorityID = '0; Rotating_priority = 1'b0;
    INTA_n = 1'b1; EOI = 1'b0; SEOI = 1'b0; EOI_level = '0; VectorBase = '0;
`ifdef PIC_AEOI_EN
    AEOI = 1'b0;
`endif
    step();
    step();
    chk("rst_int",  8'(INT), 8'h00);
    chk("rst_is",   IS_status, 8'h00);
    chk("rst_ls",   8'(last_serviced), 8'h07);
    chk("rst_irr",  IRR_clear, 8'h00);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_en",   8'(data_out_en), 8'h00);
    reset = 1'b0;

    // Nested ack of level 1, vector base 0x08 -> vector 0x41
    VectorBase = 5'h08; PriorityID = 3'd1; INTFLAG = 1'b1;
    step();
    chk("ack_int_up", 8'(INT), 8'h01);
    INTA_n = 1'b0;
    step();
    chk("ack1_is",   IS_status, 8'h02);
    chk("ack1_irr",  IRR_clear, 8'h02);
    chk("ack1_int",  8'(INT), 8'h00);
    chk("ack1_en",   8'(data_out_en), 8'h00);
    INTFLAG = 1'b0;
    step();
    chk("irr_1cyc",  IRR_clear, 8'h00);
    INTA_n = 1'b1;
    step();
    chk("ack1_rise_en", 8'(data_out_en), 8'h00);
    INTA_n = 1'b0;
    step();
    chk("ack2_dout", data_out, 8'h41);
    chk("ack2_en",   8'(data_out_en), 8'h01);
    step();
    chk("ack2_en_hold", 8'(data_out_en), 8'h01);
    INTA_n = 1'b1;
    step();
    chk("ack2_rise_en",   8'(data_out_en), 8'h00);
    chk("ack2_rise_dout", data_out, 8'h41);
    chk("ack2_is",        IS_status, 8'h02);

    // Fixed-priority non-specific EOI
    ack(3'd2);
    chk("fix_is_pre", IS_status, 8'h06);
    EOI = 1'b1;
    step();
    EOI = 1'b0;
    chk("fix_eoi_is", IS_status, 8'h04);
    chk("fix_eoi_ls", 8'(last_serviced), 8'h07);

    // Build last_serviced=5, IS=0x41, then rotating EOIs
    Rotating_priority = 1'b1; SEOI = 1'b1; EOI_level = 3'd5;
    step();
    chk("seoi_rot_ls", 8'(last_serviced), 8'h05);
    chk("seoi_rot_is", IS_status, 8'h04);
    Rotating_priority = 1'b0; EOI_level = 3'd2;
    step();
    SEOI = 1'b0;
    chk("seoi_fix_is", IS_status, 8'h00);
    chk("seoi_fix_ls", 8'(last_serviced), 8'h05);
    ack(3'd0);
    ack(3'd6);
    chk("rot_is_pre", IS_status, 8'h41);
    Rotating_priority = 1'b1; EOI = 1'b1;
    step();
    chk("rot1_is", IS_status, 8'h01);
    chk("rot1_ls", 8'(last_serviced), 8'h06);
    step();
    chk("rot2_is", IS_status, 8'h00);
    chk("rot2_ls", 8'(last_serviced), 8'h00);
    step();
    EOI = 1'b0;
    chk("rot_empty_is", IS_status, 8'h00);
    chk("rot_empty_ls", 8'(last_serviced), 8'h00);
    Rotating_priority = 1'b0;

    // INTFLAG withdrawn before INTA, then spurious acknowledge
    INTFLAG = 1'b1;
    step();
    chk("sp_int_up", 8'(INT), 8'h01);
    INTFLAG = 1'b0;
    step();
    chk("sp_withdraw_int", 8'(INT), 8'h00);
    INTFLAG = 1'b1;
    step();
    INTFLAG = 1'b0; INTA_n = 1'b0;
    step();
    chk("sp_ack1_int", 8'(INT), 8'h00);
    chk("sp_ack1_irr", IRR_clear, 8'h00);
    chk("sp_ack1_is",  IS_status, 8'h00);
    INTA_n = 1'b1;
    step();
    INTA_n = 1'b0;
    step();
    chk("sp_dout", data_out, 8'h47);
    chk("sp_en",   8'(data_out_en), 8'h01);
    INTA_n = 1'b1;
    step();

    // SEOI beats EOI in the same cycle
    ack(3'd0);
    ack(3'd7);
    chk("col_is_pre", IS_status, 8'h81);
    EOI = 1'b1; SEOI = 1'b1; EOI_level = 3'd7;
    step();
    EOI = 1'b0; SEOI = 1'b0;
    chk("col_is", IS_status, 8'h01);

    // EOI targeting the bit being set by INTA-1: set wins
    INTFLAG = 1'b1; PriorityID = 3'd0;
    step();
    INTA_n = 1'b0; EOI = 1'b1;
    step();
    EOI = 1'b0;
    chk("setwin_is",  IS_status, 8'h01);
    chk("setwin_irr", IRR_clear, 8'h01);
    INTFLAG = 1'b0; INTA_n = 1'b1;
    step();
    INTA_n = 1'b0;
    step();
    chk("pre_rst_en", 8'(data_out_en), 8'h01);

    // Asynchronous reset in ACK2, INTA_n held low across release
    reset = 1'b1;
    #1;
    chk("mid_rst_int",  8'(INT), 8'h00);
    chk("mid_rst_is",   IS_status, 8'h00);
    chk("mid_rst_ls",   8'(last_serviced), 8'h07);
    chk("mid_rst_dout", data_out, 8'h00);
    chk("mid_rst_en",   8'(data_out_en), 8'h00);
    step();
    reset = 1'b0;
    step();
    chk("held_idle_int", 8'(INT), 8'h00);
    INTFLAG = 1'b1; PriorityID = 3'd4;
    step();
    chk("held_pend_int", 8'(INT), 8'h01);
    step();
    chk("held_no_ack_is", IS_status, 8'h00);
    chk("held_no_ack_int", 8'(INT), 8'h01);
    INTFLAG = 1'b0; INTA_n = 1'b1;
    step();
    chk("held_drop_int", 8'(INT), 8'h00);

`ifdef PIC_AEOI_EN
    AEOI = 1'b1; Rotating_priority = 1'b1;
    INTFLAG = 1'b1; PriorityID = 3'd3;
    step();
    INTA_n = 1'b0;
    step();
    chk("aeoi_set_is", IS_status, 8'h08);
    INTFLAG = 1'b0; INTA_n = 1'b1;
    step();
    INTA_n = 1'b0;
    step();
    chk("aeoi_ack2_is", IS_status, 8'h08);
    INTA_n = 1'b1;
    step();
    chk("aeoi_rise_is", IS_status, 8'h00);
    chk("aeoi_rise_ls", 8'(last_serviced), 8'h03);
    chk("aeoi_rise_en", 8'(data_out_en), 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
